// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: byte stream from the SPI slave plus the register bus.
// slave = bridge side, master = SPI slave / register file side.
interface spi_reg_bridge_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = DWIDTH - 1
);
    logic              ss;
    logic [DWIDTH-1:0] rx_buffer;
    logic              rx_dv;
    logic [DWIDTH-1:0] tx_buffer;
    logic              wr;
    logic              tx_halt;
    logic [AWIDTH-1:0] reg_addr;
    logic [DWIDTH-1:0] reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [DWIDTH-1:0] reg_rdata;
    logic              busy;

    modport slave (
        input  ss,
        input  rx_buffer,
        input  rx_dv,
        input  tx_halt,
        input  reg_rdata,
        output tx_buffer,
        output wr,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        output busy
    );

    modport master (
        output ss,
        output rx_buffer,
        output rx_dv,
        output tx_halt,
        output reg_rdata,
        input  tx_buffer,
        input  wr,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        input  busy
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: command/auto-increment register access over SPI bytes.
// Optional macro SPI_REG_BRIDGE_ECHO_EN: echo written bytes back on MISO.
module spi_reg_bridge #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = DWIDTH - 1,
    parameter int NREGS  = 16
) (
    input  logic            clk,
    input  logic            rst,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_FETCH,
        S_CAPT,
        S_LOAD,
        S_RDWAIT
    } state_t;

    localparam logic [AWIDTH:0]   LP_NREGS = (AWIDTH + 1)'(NREGS);
    localparam logic [AWIDTH-1:0] LP_LAST  = AWIDTH'(NREGS - 1);

    state_t            r_state;
    state_t            w_state;
    logic              r_ss_meta;
    logic              r_ss_n_s;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] w_addr;
    logic              r_wmode;
    logic              w_wmode;
    logic              r_pend;
    logic              w_pend;
    logic [DWIDTH-1:0] r_tx;
    logic [DWIDTH-1:0] w_tx;
    logic              r_wr;
    logic              w_wr;
    logic [AWIDTH-1:0] r_raddr;
    logic [AWIDTH-1:0] w_raddr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] w_wdata;
    logic              r_we;
    logic              w_we;
    logic              r_re;
    logic              w_re;

    logic [AWIDTH-1:0] w_addr_inc;
    logic [AWIDTH-1:0] w_cmd_addr;
    logic              w_inr;
    logic              w_inr_inc;
    logic              w_inr_cmd;

    function automatic logic f_inr(input logic [AWIDTH-1:0] a);
        return {1'b0, a} < LP_NREGS;
    endfunction

    assign w_addr_inc = (r_addr == LP_LAST) ? '0 : r_addr + AWIDTH'(1);
    assign w_cmd_addr = bus.rx_buffer[AWIDTH-1:0];
    assign w_inr      = f_inr(r_addr);
    assign w_inr_inc  = f_inr(w_addr_inc);
    assign w_inr_cmd  = f_inr(w_cmd_addr);

    // Two-stage synchronizer for the raw chip select; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_meta <= 1'b1;
            r_ss_n_s  <= 1'b1;
        end else begin
            r_ss_meta <= bus.ss;
            r_ss_n_s  <= r_ss_meta;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wmode <= 1'b0;
            r_pend  <= 1'b0;
            r_tx    <= '0;
            r_wr    <= 1'b0;
            r_raddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_wmode <= w_wmode;
            r_pend  <= w_pend;
            r_tx    <= w_tx;
            r_wr    <= w_wr;
            r_raddr <= w_raddr;
            r_wdata <= w_wdata;
            r_we    <= w_we;
            r_re    <= w_re;
        end
    end

    // Next-state and next-output decode; a released chip select wins.
    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_wmode = r_wmode;
        w_pend  = r_pend;
        w_tx    = r_tx;
        w_wr    = r_wr;
        w_raddr = r_raddr;
        w_wdata = r_wdata;
        w_we    = 1'b0;
        w_re    = 1'b0;
        if (r_ss_n_s) begin
            w_state = S_IDLE;
            w_wr    = 1'b0;
            w_pend  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state = S_CMD;
                end
                S_CMD: begin
                    if (bus.rx_dv) begin
                        w_addr  = w_cmd_addr;
                        w_wmode = bus.rx_buffer[DWIDTH-1];
                        if (bus.rx_buffer[DWIDTH-1]) begin
                            w_state = S_WRITE;
                        end else begin
                            w_state = S_FETCH;
                            w_re    = w_inr_cmd;
                            if (w_inr_cmd) w_raddr = w_cmd_addr;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.rx_dv) begin
                        w_we   = w_inr;
                        w_addr = w_addr_inc;
                        if (w_inr) begin
                            w_raddr = r_addr;
                            w_wdata = bus.rx_buffer;
                        end
`ifdef SPI_REG_BRIDGE_ECHO_EN
                        w_tx    = bus.rx_buffer;
                        w_wr    = 1'b1;
                        w_state = S_LOAD;
`endif
                    end
                end
                S_FETCH: begin
                    w_state = S_CAPT;
                    if (bus.rx_dv) w_pend = 1'b1;
                end
                S_CAPT: begin
                    w_tx    = w_inr ? bus.reg_rdata : '0;
                    w_wr    = 1'b1;
                    w_state = S_LOAD;
                    if (bus.rx_dv) w_pend = 1'b1;
                end
                S_LOAD: begin
                    if (r_wmode) begin
                        // echo path: a new write byte reloads the echo
                        if (bus.rx_dv) begin
                            w_we   = w_inr;
                            w_addr = w_addr_inc;
                            if (w_inr) begin
                                w_raddr = r_addr;
                                w_wdata = bus.rx_buffer;
                            end
                            w_tx = bus.rx_buffer;
                            w_wr = 1'b1;
                        end else if (!bus.tx_halt) begin
                            w_wr    = 1'b0;
                            w_state = S_WRITE;
                        end
                    end else if (!bus.tx_halt) begin
                        w_wr   = 1'b0;
                        w_addr = w_addr_inc;
                        if (bus.rx_dv || r_pend) begin
                            w_pend  = 1'b0;
                            w_state = S_FETCH;
                            w_re    = w_inr_inc;
                            if (w_inr_inc) w_raddr = w_addr_inc;
                        end else begin
                            w_state = S_RDWAIT;
                        end
                    end else if (bus.rx_dv) begin
                        w_pend = 1'b1;
                    end
                end
                S_RDWAIT: begin
                    if (bus.rx_dv) begin
                        w_state = S_FETCH;
                        w_re    = w_inr;
                        if (w_inr) w_raddr = r_addr;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_buffer = r_tx;
    assign bus.wr        = r_wr;
    assign bus.reg_addr  = r_raddr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = (r_state != S_IDLE) && !r_ss_n_s;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed checks for spi_reg_bridge.
// Register file and SPI-side loads are modelled/logged locally.
module tb_spi_reg_bridge;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    spi_reg_bridge_if #(.DWIDTH(8), .AWIDTH(7)) bus_if ();

    spi_reg_bridge #(.DWIDTH(8), .AWIDTH(7), .NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:127] = '{default: 8'h00};
    logic [15:0] we_q [$];
    logic [15:0] re_q [$];
    logic [15:0] ld_q [$];
    int          both_cnt = 0;
    logic        wr_seen  = 1'b0;

    initial bus_if.reg_rdata = 8'h00;

    always @(posedge clk) begin
        if (bus_if.reg_we) begin
            mem[bus_if.reg_addr] <= bus_if.reg_wdata;
            we_q.push_back({1'b0, bus_if.reg_addr, bus_if.reg_wdata});
        end
        if (bus_if.reg_re) begin
            bus_if.reg_rdata <= mem[bus_if.reg_addr];
            re_q.push_back({9'd0, bus_if.reg_addr});
        end
        if (bus_if.reg_we && bus_if.reg_re) both_cnt++;
        if (bus_if.wr) wr_seen = 1'b1;
        if (bus_if.wr && !bus_if.tx_halt) ld_q.push_back({8'd0, bus_if.tx_buffer});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus_if.rx_buffer = b;
        bus_if.rx_dv     = 1'b1;
        tick();
        bus_if.rx_dv     = 1'b0;
    endtask

    task automatic clr();
        we_q.delete();
        re_q.delete();
        ld_q.delete();
        wr_seen = 1'b0;
    endtask

    task automatic ss_start();
        bus_if.ss = 1'b0;
        idle(3);
    endtask

    task automatic ss_end();
        bus_if.ss = 1'b1;
        idle(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        bus_if.ss        = 1'b1;
        bus_if.rx_buffer = 8'h00;
        bus_if.rx_dv     = 1'b0;
        bus_if.tx_halt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",    bus_if.tx_buffer, 0);
        chk("rst_wr",    bus_if.wr,        0);
        chk("rst_addr",  bus_if.reg_addr,  0);
        chk("rst_wdata", bus_if.reg_wdata, 0);
        chk("rst_we",    bus_if.reg_we,    0);
        chk("rst_re",    bus_if.reg_re,    0);
        chk("rst_busy",  bus_if.busy,      0);
        rst = 1'b0;
        tick();

        // write burst at 3
        clr();
        ss_start();
        chk("busy_open", bus_if.busy, 1);
        send(8'h83); idle(3);
        send(8'h11); idle(3);
        send(8'h22); idle(3);
        chk("wb_cnt", we_q.size(), 2);
        chk("wb_0",   we_q[0], 16'h0311);
        chk("wb_1",   we_q[1], 16'h0422);
        chk("wb_re",  re_q.size(), 0);
        bus_if.ss = 1'b1;
        tick();
        chk("busy_1clk", bus_if.busy, 1);
        tick();
        chk("busy_2clk", bus_if.busy, 0);
        idle(3);

        // preload 14,15,0 with a wrapping write
        clr();
        ss_start();
        send(8'h8E); idle(3);
        send(8'hAB); idle(3);
        send(8'hCD); idle(3);
        send(8'hEF); idle(3);
        ss_end();
        chk("wwrap_cnt", we_q.size(), 3);
        chk("wwrap_1",   we_q[1], 16'h0FCD);
        chk("wwrap_2",   we_q[2], 16'h00EF);

        // read burst with wrap, one dummy arriving during LOAD
        clr();
        bus_if.tx_halt = 1'b1;
        ss_start();
        send(8'h0E);
        chk("rd_re0",   bus_if.reg_re,   1);
        chk("rd_addr0", bus_if.reg_addr, 14);
        tick(); tick();
        chk("rd_wr0",   bus_if.wr,        1);
        chk("rd_tx0",   bus_if.tx_buffer, 8'hAB);
        idle(2);
        chk("rd_hold",  bus_if.wr,        1);
        bus_if.tx_halt = 1'b0;
        tick();
        chk("rd_wrrel", bus_if.wr,        0);
        bus_if.tx_halt = 1'b1;
        idle(2);
        send(8'h00);
        tick(); tick();
        chk("rd_tx1",   bus_if.tx_buffer, 8'hCD);
        send(8'h00);
        bus_if.tx_halt = 1'b0;
        tick();
        chk("rd_pend_re",   bus_if.reg_re,   1);
        chk("rd_pend_addr", bus_if.reg_addr, 0);
        chk("rd_pend_wr",   bus_if.wr,       0);
        bus_if.tx_halt = 1'b1;
        tick(); tick();
        chk("rd_tx2",   bus_if.tx_buffer, 8'hEF);
        bus_if.tx_halt = 1'b0;
        tick();
        ss_end();
        chk("rd_re_cnt", re_q.size(), 3);
        chk("rd_re_1",   re_q[1], 15);
        chk("rd_re_2",   re_q[2], 0);
        chk("rd_ld_cnt", ld_q.size(), 3);
        chk("rd_ld_0",   ld_q[0], 8'hAB);
        chk("rd_ld_1",   ld_q[1], 8'hCD);
        chk("rd_ld_2",   ld_q[2], 8'hEF);
        chk("rd_we",     we_q.size(), 0);

        // out-of-range write and read
        clr();
        ss_start();
        send(8'hA0); idle(3);
        send(8'h55); idle(3);
        ss_end();
        chk("oor_we", we_q.size(), 0);
        clr();
        ss_start();
        send(8'h20);
        tick(); tick();
        chk("oor_tx", bus_if.tx_buffer, 8'h00);
        chk("oor_wr", bus_if.wr,        1);
        idle(2);
        ss_end();
        chk("oor_re",  re_q.size(), 0);
        chk("oor_ld",  ld_q.size(), 1);

        // abort after a lone write command
        ss_start();
        send(8'h82); idle(3);
        send(8'h77); idle(3);
        ss_end();
        clr();
        ss_start();
        send(8'h85); idle(2);
        ss_end();
        ss_start();
        send(8'h02); idle(4);
        ss_end();
        chk("abt_we",  we_q.size(), 0);
        chk("abt_re",  re_q.size(), 1);
        chk("abt_ra",  re_q[0], 2);
        chk("abt_ld",  ld_q[0], 8'h77);

        // chip select release beats a same-cycle byte
        clr();
        ss_start();
        send(8'h81); idle(3);
        bus_if.ss = 1'b1;
        tick(); tick();
        send(8'h99); idle(3);
        chk("sswin_we", we_q.size(), 0);

        // async reset while LOAD is held
        clr();
        bus_if.tx_halt = 1'b1;
        ss_start();
        send(8'h05);
        tick(); tick();
        chk("rl_wr_pre", bus_if.wr, 1);
        #2 rst = 1'b1;
        #1;
        chk("rl_wr",   bus_if.wr,        0);
        chk("rl_busy", bus_if.busy,      0);
        chk("rl_tx",   bus_if.tx_buffer, 0);
        chk("rl_re",   bus_if.reg_re,    0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        clr();
        idle(6);
        chk("rl_post_we", we_q.size(), 0);
        chk("rl_post_re", re_q.size(), 0);
        chk("rl_post_wr", wr_seen,     0);
        bus_if.ss      = 1'b1;
        bus_if.tx_halt = 1'b0;
        idle(4);

        // echo of written bytes
        clr();
        ss_start();
        send(8'h81); idle(3);
        send(8'h5A);
        chk("ec_we", bus_if.reg_we, 1);
`ifdef SPI_REG_BRIDGE_ECHO_EN
        chk("ec_wr", bus_if.wr,        1);
        chk("ec_tx", bus_if.tx_buffer, 8'h5A);
`else
        chk("ec_wr", bus_if.wr,        0);
`endif
        idle(3);
        send(8'h3C); idle(3);
        ss_end();
        chk("ec_we_cnt", we_q.size(), 2);
        chk("ec_we_0",   we_q[0], 16'h015A);
`ifdef SPI_REG_BRIDGE_ECHO_EN
        chk("ec_ld_cnt", ld_q.size(), 2);
        chk("ec_ld_0",   ld_q[0], 8'h5A);
        chk("ec_ld_1",   ld_q[1], 8'h3C);
`else
        chk("ec_noload", wr_seen, 0);
`endif

        chk("we_re_excl", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sits directly downstream of the SPI slave in the RTC. Consumes received bytes (rx_buffer/rx_dv) and drives the slave's transmit side (tx_buffer/wr/tx_halt).
- Decodes a command byte, then performs auto-incrementing register writes or reads on a simple single-cycle register bus into the RTC register file.
- One transaction spans one chip-select assertion.

Parameters:
- DWIDTH, 8, byte width; must match the SPI slave TXWIDTH/RXWIDTH.
- AWIDTH, 7, register address width; fixed at DWIDTH-1.
- NREGS, 16, number of implemented registers, 1..2^AWIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ss  in  1  SPI chip select, active-low, raw from pad.
- rx_buffer  in  DWIDTH  received byte from SPI slave.
- rx_dv  in  1  one-cycle strobe: rx_buffer valid.
- tx_buffer  out  DWIDTH  byte to send on next SPI byte.
- wr  out  1  load request to SPI slave.
- tx_halt  in  1  SPI slave busy shifting; a load happens only on wr & ~tx_halt.
- reg_addr  out  AWIDTH  register bus address.
- reg_wdata  out  DWIDTH  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  DWIDTH  read data; valid the cycle after reg_re.
- busy  out  1  high while a transaction is open (ss synced low).

Behaviour:
- Reset: all outputs 0 (tx_buffer, wr, reg_addr, reg_wdata, reg_we, reg_re, busy); state IDLE; internal address 0.
- Chip select: ss passes through a 2-FF synchronizer into ss_n_s.
- ss_n_s high forces IDLE from any state next cycle. wr, reg_we and reg_re are cleared and busy drops. This is how an aborted transaction is handled.
- States:
  - IDLE: wait for ss_n_s low, then go to CMD with busy=1.
  - CMD: on rx_dv, command = rx_buffer. Bit DWIDTH-1 set means write, clear means read. Bits AWIDTH-1:0 are the start address. A write goes to WRITE. A read goes to FETCH.
  - WRITE: on each rx_dv, reg_we=1 for one cycle with reg_addr=addr and reg_wdata=rx_buffer, then addr increments.
  - FETCH: reg_re=1 for one cycle at addr. Next cycle, capture reg_rdata into tx_buffer and go to LOAD.
  - LOAD: hold wr=1 until a cycle with tx_halt=0, then deassert wr, increment addr and go to RDWAIT.
  - RDWAIT: on each rx_dv (master dummy/clock-out byte), go to FETCH.
- Read latency: wr first asserts 2 clk after the rx_dv that triggered the fetch. The master must leave at least 4 clk of idle sclk after a command byte.
- Address increment wraps NREGS-1 -> 0.
- Out-of-range (addr >= NREGS):
  - Writes issue no reg_we; addr still increments.
  - Reads issue no reg_re and load tx_buffer=0x00.
- Simultaneous events:
  - ss_n_s rising in the same cycle as rx_dv: ss wins, byte dropped, no bus strobe.
  - rx_dv arriving while in LOAD: the pending load completes first, and the fetch for the new byte follows immediately after.
- reg_we and reg_re are never high in the same cycle.
- Reset mid-operation: asynchronous clear to reset values regardless of state; in-flight bus strobes are dropped.

Optional Feature:
- Macro: SPI_REG_BRIDGE_ECHO_EN.
- Defined: in WRITE, each written byte is also loaded into tx_buffer via the LOAD handshake. The master sees the previous byte echoed during the following byte, for link checking.
- Undefined: WRITE never asserts wr; tx_buffer holds its last value.

Test Plan:
- Write burst: ss low, bytes 0x83,0x11,0x22, ss high -> reg_we at addr 3 data 0x11, then addr 4 data 0x22; no reg_re; busy drops 2 clk after ss rises.
- Read burst with wrap: regs 14=0xAB, 15=0xCD, 0=0xEF; send 0x0E then two dummies -> reg_re at 14,15,0; tx_buffer loads 0xAB,0xCD,0xEF, each wr held until tx_halt=0.
- Out-of-range: write 0xA0,0x55 -> no reg_we. Read 0x20 -> tx_buffer=0x00 and no reg_re.
- Abort: ss high after 0x85 only, then new transaction 0x02 -> treated as a read command at addr 2, not as data to addr 5.
- Async reset asserted during LOAD with tx_halt=1 -> wr, busy, tx_buffer 0 in the same cycle; no strobes after release until a new ss assertion.
- ECHO_EN: write 0x81,0x5A,0x3C -> wr loads 0x5A after the second byte. Without the macro, wr stays 0 for the whole transaction.
